// File: rtl/ir_tx_pkg.sv
// Shared constants and types for the IR transmitter.
package ir_tx_pkg;

    localparam logic [1:0] IR_MODE_BIPHASE = 2'd0;
    localparam logic [1:0] IR_MODE_PDIST   = 2'd1;
    localparam logic [1:0] IR_MODE_PLEN    = 2'd2;
    localparam logic [1:0] IR_MODE_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEG_A = 2'd1,
        ST_SEG_B = 2'd2,
        ST_DONE  = 2'd3
    } ir_state_e;

endpackage

// File: rtl/ir_carrier_gen.sv
// Restartable carrier divider: one unit tick per carrier period.
// carrier_nxt_c is the carrier level for the upcoming cycle, so the
// encoder can register its line output in step with the state.
module ir_carrier_gen #(
    parameter int unsigned CAR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CAR_W-1:0] div,
    input  logic [CAR_W-1:0] high,
    input  logic             restart,
    output logic             carrier_nxt_c,
    output logic             tick_c
);

    logic [CAR_W-1:0] cnt_q;
    logic [CAR_W-1:0] cnt_d;

    // Last cycle of the current carrier period.
    assign tick_c = (cnt_q == CAR_W'(div - CAR_W'(1)));

    // Count 0..div-1, wrapping on tick, forced to 0 on restart.
    always_comb begin
        cnt_d = CAR_W'(cnt_q + CAR_W'(1));
        if (restart || tick_c) begin
            cnt_d = '0;
        end
    end

    // High phase occupies the first 'high' cycles of each period.
    assign carrier_nxt_c = (cnt_d < high);

    // Carrier phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_tx_encoder.sv
// IR remote transmitter: serialises a payload LSB first in bi-phase,
// pulse-distance or pulse-length coding with a gated carrier.
module ir_tx_encoder
    import ir_tx_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BITCNT_W = 6,
    parameter int unsigned CAR_W    = 16,
    parameter int unsigned UNIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_mode,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [BITCNT_W-1:0] i_bit_cnt,
    input  logic [CAR_W-1:0]    i_car_div,
    input  logic [CAR_W-1:0]    i_car_high,
    input  logic                i_car_en,
    input  logic [UNIT_W-1:0]   i_num0,
    input  logic [UNIT_W-1:0]   i_num1,
    input  logic [UNIT_W-1:0]   i_num2,
    output logic                o_busy,
    output logic                o_done,
    output logic [BITCNT_W-1:0] o_bit_idx,
    output logic                o_ir_dout
);

    ir_state_e           state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_cl, bit_idx_d;
    logic [CAR_W-1:0]    div_q, div_d, div_cl;
    logic [CAR_W-1:0]    high_q, high_d, high_cl;
    logic                car_en_q, car_en_d;
    logic [UNIT_W-1:0]   num0_q, num0_d, num1_q, num1_d, num2_q, num2_d;
    logic [UNIT_W-1:0]   seg_cnt_q, seg_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [UNIT_W:0]     desc;
    logic                start, in_seg_q, in_seg_d, seg_end, last_bit;
    logic                restart, tick, car_nxt, dout_d;

    // Mark flag and length (0 read as 1) of the segment for a given bit/half.
    function automatic logic [UNIT_W:0] seg_desc(input logic [1:0] mode, input logic bit_v,
                                                 input logic half_b, input logic [UNIT_W-1:0] n0,
                                                 input logic [UNIT_W-1:0] n1, input logic [UNIT_W-1:0] n2);
        logic              mark;
        logic [UNIT_W-1:0] len;
        mark = 1'b0;
        len  = n0;
        case (mode)
            IR_MODE_BIPHASE: begin
                mark = half_b ? bit_v : ~bit_v;
                len  = n0;
            end
            IR_MODE_PDIST: begin
                mark = ~half_b;
                len  = half_b ? (bit_v ? n2 : n1) : n0;
            end
            IR_MODE_PLEN: begin
                mark = ~half_b;
                len  = half_b ? n2 : (bit_v ? n1 : n0);
            end
            default: ;
        endcase
        if (len == '0) begin
            len = UNIT_W'(1);
        end
        return {mark, len};
    endfunction

    assign start    = (state_q == ST_IDLE) && i_start;
    assign in_seg_q = (state_q == ST_SEG_A) || (state_q == ST_SEG_B);
    assign in_seg_d = (state_d == ST_SEG_A) || (state_d == ST_SEG_B);
    assign seg_end  = in_seg_q && tick && (seg_cnt_q == UNIT_W'(1));
    assign last_bit = (BITCNT_W'(o_bit_idx + BITCNT_W'(1)) == bit_cnt_q);

    // Clamp and latch the configuration on an accepted start.
    always_comb begin
        bit_cnt_cl = (i_bit_cnt > BITCNT_W'(DATA_W)) ? BITCNT_W'(DATA_W) : i_bit_cnt;
        div_cl     = (i_car_div < CAR_W'(2)) ? CAR_W'(2) : i_car_div;
        high_cl    = (i_car_high > CAR_W'(div_cl - CAR_W'(1))) ? CAR_W'(div_cl - CAR_W'(1)) : i_car_high;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        high_d     = high_q;
        car_en_d   = car_en_q;
        num0_d     = num0_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        if (start) begin
            mode_d    = i_mode;
            bit_cnt_d = bit_cnt_cl;
            div_d     = div_cl;
            high_d    = high_cl;
            car_en_d  = i_car_en;
            num0_d    = i_num0;
            num1_d    = i_num1;
            num2_d    = i_num2;
        end
    end

    // Next-state logic, payload shifting and bit index.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_idx_d = o_bit_idx;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d    = i_data;
                    bit_idx_d = '0;
                    if ((bit_cnt_d == '0) || (mode_d == IR_MODE_RSVD)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEG_A;
                    end
                end
            end
            ST_SEG_A: begin
                if (seg_end) begin
                    state_d = ST_SEG_B;
                end
            end
            ST_SEG_B: begin
                if (seg_end) begin
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_SEG_A;
                        data_d    = data_q >> 1;
                        bit_idx_d = BITCNT_W'(o_bit_idx + BITCNT_W'(1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Descriptor of the segment that will be active next cycle.
    assign desc = seg_desc(mode_d, data_d[0], (state_d == ST_SEG_B), num0_d, num1_d, num2_d);

    // Segment counter: reload on entry, count down on unit ticks.
    always_comb begin
        seg_cnt_d = seg_cnt_q;
        if (in_seg_d && (state_d != state_q)) begin
            seg_cnt_d = desc[UNIT_W-1:0];
        end else if (in_seg_q && tick && !seg_end) begin
            seg_cnt_d = UNIT_W'(seg_cnt_q - UNIT_W'(1));
        end
    end

    // Carrier phase restarts on every segment boundary and while idle.
    assign restart = (state_d != state_q) || !in_seg_q;

    ir_carrier_gen #(
        .CAR_W (CAR_W)
    ) u_carrier (
        .clk           (clk),
        .rst_n         (rst_n),
        .div           (div_d),
        .high          (high_d),
        .restart       (restart),
        .carrier_nxt_c (car_nxt),
        .tick_c        (tick)
    );

    // Line level for the next cycle.
    assign dout_d = in_seg_d && desc[UNIT_W] && (car_en_d ? car_nxt : 1'b1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            high_q    <= '0;
            car_en_q  <= 1'b0;
            num0_q    <= '0;
            num1_q    <= '0;
            num2_q    <= '0;
            data_q    <= '0;
            seg_cnt_q <= '0;
            o_bit_idx <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_ir_dout <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
            car_en_q  <= car_en_d;
            num0_q    <= num0_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            data_q    <= data_d;
            seg_cnt_q <= seg_cnt_d;
            o_bit_idx <= bit_idx_d;
            o_busy    <= in_seg_d;
            o_done    <= (state_d == ST_DONE);
            o_ir_dout <= dout_d;
        end
    end

endmodule

// File: doc/ir_tx_encoder.md
Name: ir_tx_encoder

Overview:
Synthesizable IR remote-control transmitter. It is the RTL successor to the bench-side IR stimulus model, and it sits between a register/host interface and the IR LED driver pin. It serialises up to DATA_W bits, LSB first, using one of three line codings: bi-phase, pulse-distance or pulse-length. Mark segments are gated by a programmable carrier, with period and duty set at run time in clk cycles. Segment lengths are counted in whole carrier periods.

Parameters:
DATA_W, 32, maximum payload width.
BITCNT_W, 6, width of the bit-count input (must satisfy 2**BITCNT_W > DATA_W).
CAR_W, 16, width of the carrier period and high-time inputs, in clk cycles.
UNIT_W, 8, width of the segment-length inputs, in carrier periods.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
i_start  in  1  single-cycle request; sampled only in IDLE.
i_mode  in  2  coding: 0 = bi-phase, 1 = pulse-distance, 2 = pulse-length, 3 = reserved.
i_data  in  DATA_W  payload, sent LSB first.
i_bit_cnt  in  BITCNT_W  number of bits to send; values above DATA_W are clamped to DATA_W.
i_car_div  in  CAR_W  carrier period in clk cycles; values below 2 are treated as 2.
i_car_high  in  CAR_W  carrier high time in clk cycles; clamped to i_car_div-1; 0 gives a flat-low mark.
i_car_en  in  1  1 = carrier-modulated mark; 0 = solid-high mark.
i_num0  in  UNIT_W  bi-phase half-bit / distance mark / length mark for a 0.
i_num1  in  UNIT_W  distance space for a 0 / length mark for a 1.
i_num2  in  UNIT_W  distance space for a 1 / length space.
o_busy  out  1  high while a frame is in progress.
o_done  out  1  one-cycle pulse at frame end.
o_bit_idx  out  BITCNT_W  index of the bit currently being sent.
o_ir_dout  out  1  registered IR output.

Behaviour:
- Reset (async, rst_n=0): state IDLE; o_busy=0, o_done=0, o_bit_idx=0, o_ir_dout=0; all counters cleared. Reset mid-frame aborts immediately with no o_done.
- Latching: in IDLE, i_start=1 latches every config input (after clamping). From the next cycle, o_busy=1 and the first segment drives o_ir_dout.
- Start handling: i_start while busy is ignored. Inputs changing mid-frame have no effect.
- Degenerate frames: i_bit_cnt=0 or i_mode=3 go IDLE to DONE. o_done pulses 1 cycle after start; o_busy stays 0; o_ir_dout stays 0.
- States: IDLE, SEG_A (first half of bit), SEG_B (second half of bit), DONE.
- SEG_A to SEG_B after the first segment's length expires.
- SEG_B to SEG_A: taken when more bits remain; the data shift register shifts right and o_bit_idx increments.
- SEG_B to DONE: taken after the last bit. DONE lasts 1 cycle (o_done=1, o_busy=0), then IDLE. A back-to-back i_start is accepted on the cycle after DONE.
- Segment contents per coding (mark = carrier, space = 0):
  - Bi-phase: bit 0 = mark(num0) then space(num0); bit 1 = space(num0) then mark(num0).
  - Pulse-distance: mark(num0), then space(num1) for a 0 or space(num2) for a 1.
  - Pulse-length: mark(num0) for a 0 or mark(num1) for a 1, then space(num2).
- A segment length of 0 is treated as 1.
- Segment timing: a segment of N lasts exactly N*car_div clk cycles. The carrier counter restarts at 0 on every segment entry, so every mark starts on a carrier high phase.
- Carrier: car_cnt counts 0..car_div-1 and wraps. carrier = (car_cnt < car_high). A unit tick occurs when car_cnt == car_div-1; the segment counter decrements on each tick.
- Output: o_ir_dout <= mark_seg & (i_car_en ? carrier : 1). It is 0 in IDLE and DONE; the frame ends with the line low.
- Widths: segment counter is UNIT_W; car_cnt is CAR_W. No arithmetic overflows at the maximum values.

Decomposition:
- Package ir_tx_pkg: mode constants IR_MODE_BIPHASE=0, IR_MODE_PDIST=1, IR_MODE_PLEN=2; state enum.
- Sub-module ir_carrier_gen: restartable divider with inputs div, high, restart. It outputs carrier and unit tick.

Test Plan:
- Bi-phase: car_div=4, high=1, car_en=1, mode 0, data=2'b10, bit_cnt=2, num0=2.
  - Required output over 32 clks: 8 clks of 1000 pattern, then 8 low, 8 low, 8 clks of 1000 pattern.
  - o_done pulses 33 cycles after start; o_bit_idx goes 0 to 1 at clk 16.
- Pulse-distance: mode 1, car_en=0, car_div=2, data=1'b1, bit_cnt=1, num0=3, num1=3, num2=6. Required: 6 high clks, then 12 low clks, then o_done.
- Pulse-length: mode 2, car_en=0, car_div=2, data=2'b01, bit_cnt=2, num0=2, num1=4, num2=1. Required high-run lengths: 8 clks for bit 0 (value 1), then 4 clks for bit 1 (value 0); each high run followed by 2 low clks.
- Degenerate and clamping:
  - bit_cnt=0 gives o_done at +1 with o_busy never 1.
  - mode 3 behaves the same way.
  - car_div=0 behaves as 2; car_high=9 with div=4 behaves as 3.
- Reset mid-frame: assert rst_n low during SEG_A of bit 3. All outputs go 0 asynchronously, no o_done, and a fresh start afterwards works.
- Start while busy: pulse i_start mid-frame with different data. The frame is unchanged; exactly one o_done.
